// File: rtl/dmem_arb.sv
// dmem_arb: two-port arbiter in front of a single-ported, combinational-read
// data memory. One access per two cycles (IDLE arbitration, ACCESS on the bus).
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   prio_fix                - 1: fixed priority to port 0 with starvation guard,
//                             0: round-robin
//   req/we/addr/wdata{0,1}  - per-port request and command, held until gnt
//   gnt{0,1}                - pulse in the cycle the port's access is on the bus
//   rvalid{0,1}, rdata      - read completion pulse and shared read data
//   mem_we/mem_addr/mem_wdata/mem_rdata - memory side
module dmem_arb #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prio_fix,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                win1_c;
    logic                starved_c;
    logic                last1;      // 1 = port 1 served by the most recent access
    logic [WAIT_W-1:0]   wait1;      // consecutive lost arbitrations of port 1

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration: a lone requester always wins; ties go by mode
    always_comb begin
        win1_c    = 1'b0;
        starved_c = (wait1 >= WAIT_W'(MAX_WAIT));
        if (!req0) begin
            win1_c = req1;
        end else if (!req1) begin
            win1_c = 1'b0;
        end else if (prio_fix) begin
            win1_c = starved_c;
        end else begin
            win1_c = !last1;
        end
    end

    // Registered bus command, grants, read return and arbitration history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            wait1     <= '0;
            last1     <= 1'b1;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt0      <= !win1_c;
                        gnt1      <= win1_c;
                        mem_we    <= win1_c ? we1    : we0;
                        mem_addr  <= win1_c ? addr1  : addr0;
                        mem_wdata <= win1_c ? wdata1 : wdata0;
                    end
                    // Guard counter only moves on IDLE arbitrations
                    if (!req1 || win1_c) begin
                        wait1 <= '0;
                    end else if (!starved_c) begin
                        wait1 <= wait1 + WAIT_W'(1);
                    end
                end
                ACCESS: begin
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    mem_we <= 1'b0;
                    last1  <= gnt1;
                    if (!mem_we) begin
                        rdata   <= mem_rdata;
                        rvalid0 <= gnt0;
                        rvalid1 <= gnt1;
                    end
                end
                default: begin
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: expected bus accesses are queued as requests
// are issued and retired when grants and read completions appear.
module tb_dmem_arb;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              prio_fix = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] mem     [0:255];
    logic [DATA_W-1:0] exp_mem [0:255];

    exp_t gq[$];
    exp_t rq[$];

    int n_cmp = 0;
    int n_err = 0;

    dmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .prio_fix(prio_fix),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: retire grants and read completions against the queues
    always @(negedge clk) begin
        exp_t e;
        if (gnt0 && gnt1) check("gnt_both", 1, 0);
        if (rvalid0 && rvalid1) check("rvalid_both", 1, 0);
        if (gnt0 || gnt1) begin
            if (gq.size() == 0) begin
                check("gnt_unexpected", 1, 0);
            end else begin
                e = gq.pop_front();
                check("gnt_port", 64'(gnt1), 64'(e.port));
                check("mem_we", 64'(mem_we), 64'(e.we));
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                else rq.push_back(e);
            end
        end else begin
            check("we_idle", 64'(mem_we), 0);
        end
        if (rvalid0 || rvalid1) begin
            if (rq.size() == 0) begin
                check("rvalid_unexpected", 1, 0);
            end else begin
                e = rq.pop_front();
                check("rvalid_port", 64'(rvalid1), 64'(e.port));
                check("rdata", 64'(rdata), 64'(e.data));
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt", 64'({gnt0, gnt1}), 0);
        check("rst_rvalid", 64'({rvalid0, rvalid1}), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        check("rst_rdata", 64'(rdata), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_port(input logic port, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        if (port) begin we1 = we; addr1 = a; wdata1 = d; end
        else      begin we0 = we; addr0 = a; wdata0 = d; end
    endtask

    // Single requester access; waits for its grant then drops the request
    task automatic issue(input logic port, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        exp_t e;
        int   t;
        e.port = port; e.we = we; e.addr = a;
        e.data = we ? d : exp_mem[a];
        if (we) exp_mem[a] = d;
        gq.push_back(e);
        set_port(port, we, a, d);
        if (port) req1 = 1'b1; else req0 = 1'b0 | 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(port ? gnt1 : gnt0) && t < 20);
        if (t >= 20) check("gnt_timeout", 0, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Both ports hold a read; order[i] is the port expected on the i-th grant
    task automatic hold_both(input int n, input logic [15:0] order,
                             input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        exp_t e;
        int   got, t, last;
        for (int i = 0; i < n; i++) begin
            e.port = order[i];
            e.we   = 1'b0;
            e.addr = order[i] ? a1 : a0;
            e.data = exp_mem[e.addr];
            gq.push_back(e);
        end
        set_port(1'b0, 1'b0, a0, '0);
        set_port(1'b1, 1'b0, a1, '0);
        req0 = 1'b1;
        req1 = 1'b1;
        got = 0; t = 0; last = -1;
        while (got < n && t < 200) begin
            @(negedge clk);
            t++;
            if (gnt0 || gnt1) begin
                if (last >= 0) check("gnt_gap", 64'(t - last), 2);
                last = t;
                got++;
            end
        end
        if (got < n) check("hold_timeout", 64'(got), 64'(n));
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101;
            exp_mem[i] = 32'(i) * 32'h0101_0101;
        end
        mem[8'h10] = 32'hDEAD_BEEF; exp_mem[8'h10] = 32'hDEAD_BEEF;
        mem[8'h20] = 32'h1234_5678; exp_mem[8'h20] = 32'h1234_5678;

        reset_dut();
        prio_fix = 1'b0;
        issue(1'b0, 1'b0, 8'h10, '0);              // single read
        issue(1'b1, 1'b1, 8'h84, 32'h0000_00FF);   // single write, no rvalid
        issue(1'b0, 1'b0, 8'h84, '0);              // read back the write
        issue(1'b1, 1'b0, 8'h10, '0);

        reset_dut();
        prio_fix = 1'b0;
        hold_both(4, 16'b1010, 8'h10, 8'h84);      // round-robin 0,1,0,1

        reset_dut();
        prio_fix = 1'b1;
        hold_both(10, 16'h0210, 8'h10, 8'h84);     // 0,0,0,0,1 repeating
        issue(1'b1, 1'b0, 8'h20, '0);              // lone port 1 wins in fixed mode

        prio_fix = 1'b0;
        issue(1'b0, 1'b0, 8'h05, '0);
        hold_both(2, 16'b01, 8'h06, 8'h07);        // port 0 served last -> port 1 first

        // Reset during an ACCESS write: access must be abandoned
        begin
            exp_t e;
            int   t;
            e.port = 1'b1; e.we = 1'b1; e.addr = 8'h20; e.data = 32'hCAFE_F00D;
            gq.push_back(e);
            set_port(1'b1, 1'b1, 8'h20, 32'hCAFE_F00D);
            req1 = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!gnt1 && t < 20);
            if (t >= 20) check("abort_gnt_timeout", 0, 1);
            #2;
            reset = 1'b1;
            req1  = 1'b0;
            #1;
            check("abort_mem_we", 64'(mem_we), 0);
            check("abort_gnt1", 64'(gnt1), 0);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("abort_rdata", 64'(rdata), 0);
            check("abort_rvalid", 64'({rvalid0, rvalid1}), 0);
        end
        hold_both(2, 16'b10, 8'h20, 8'h84);        // first tie after reset -> port 0; 0x20 unwritten

        repeat (3) @(negedge clk);
        check("gq_empty", 64'(gq.size()), 0);
        check("rq_empty", 64'(rq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter ADDR_W, default 8, word address width shared by both ports and memory side.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive lost arbitrations after which port 1 is forced to win in fixed-priority mode.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 prio_fix  input  1  1 = fixed priority to port 0 with starvation guard; 0 = round-robin.
REQ-007 req0/req1  input  1 each  access request; held with its command until the matching gnt is seen.
REQ-008 we0/we1  input  1 each  1 = write, 0 = read.
REQ-009 addr0/addr1  input  ADDR_W each  word address.
REQ-010 wdata0/wdata1  input  DATA_W each  write data.
REQ-011 gnt0/gnt1  output  1 each  one-cycle pulse in the cycle the port's access is on the memory bus.
REQ-012 rvalid0/rvalid1  output  1 each  one-cycle pulse; rdata holds the port's read result.
REQ-013 rdata  output  DATA_W  registered read data, shared by both ports.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, combinational from mem_addr within the same cycle.

Function
REQ-018 FSM states: IDLE, ACCESS; IDLE -> ACCESS when req0|req1 sampled high; ACCESS -> IDLE unconditionally; max throughput one access per 2 cycles.
REQ-019 In IDLE the winner's we/addr/wdata and identity are registered at the clock edge; losers' requests are not registered.
REQ-020 In ACCESS: mem_addr/mem_wdata driven from registers, mem_we = registered we, gnt of winner = 1, gnt of other = 0.
REQ-021 mem_we SHALL be 0 in every IDLE cycle; mem_addr/mem_wdata hold their last registered values in IDLE.
REQ-022 Read: mem_rdata sampled into rdata at the end of the ACCESS cycle; rvalid of winner = 1 in the following cycle; writes never assert rvalid.
REQ-023 rdata holds its value until the next read completes.
REQ-024 Round-robin (prio_fix=0): single requester always wins; both requesting -> port not served by the last access wins; last_served updated in every ACCESS.
REQ-025 Fixed (prio_fix=1): port 0 wins ties unless wait1 >= MAX_WAIT, then port 1 wins.
REQ-026 wait1 counter: increments (saturating at MAX_WAIT) on each IDLE arbitration where req1=1 and port 1 loses; clears when port 1 wins or req1=0 in IDLE; unchanged in ACCESS.
REQ-027 prio_fix may change any cycle; it takes effect at the next IDLE arbitration; wait1 is not cleared by the change.
REQ-028 gnt0 and gnt1 never high together; rvalid0 and rvalid1 never high together.
REQ-029 A requester that keeps req high after gnt is treated as a new request in the next IDLE.

Reset
REQ-030 reset=1 asynchronously forces: state IDLE, gnt0/gnt1/rvalid0/rvalid1/mem_we = 0, mem_addr/mem_wdata/rdata = 0, wait1 = 0, last_served = port 1 (port 0 wins first tie).
REQ-031 Reset during ACCESS aborts the access: mem_we drops immediately, no gnt/rvalid issued afterward for that access.
REQ-032 First arbitration occurs at the first rising edge with reset low.

Verification
REQ-033 Single read: req0=1, we0=0, addr0=0x10, memory[0x10]=0xDEADBEEF -> gnt0 next cycle with mem_addr=0x10, mem_we=0; rvalid0 cycle after, rdata=0xDEADBEEF.
REQ-034 Round-robin tie: prio_fix=0, req0=req1=1 held for 8 cycles after reset -> gnt order 0,1,0,1 on alternate cycles, never both.
REQ-035 Starvation guard: prio_fix=1, MAX_WAIT=4, req0 and req1 continuously high -> four port-0 grants then one port-1 grant, repeating; wait1 returns to 0 after port-1 grant.
REQ-036 Write: req1=1, we1=1, addr1=0x84, wdata1=0x0000_00FF -> one cycle with mem_we=1, mem_addr=0x84, mem_wdata=0xFF, gnt1=1; no rvalid1.
REQ-037 Reset mid-access: assert reset asynchronously during an ACCESS write -> mem_we and gnt fall before the next edge; after release, rdata=0 and first tie grants port 0.
